// File: rtl/data_mem_alt.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_alt
//  Description : Simple dual-port synchronous RAM used as the frame-buffer
//                data store. One write port and one read port share a single
//                clock. Read data is registered (one cycle of latency) and is
//                held between reads. Both enables are active-low.
//
//  Ports       : clk      - single clock, rising-edge sampling
//                reset    - asynchronous active-high reset (read register only)
//                wr_en    - active-low write enable
//                rd_en    - active-low read enable
//                wr_addr  - write address
//                rd_addr  - read address
//                wr_data  - write data
//                rd_data  - registered read data
//
//  Build option: DATA_MEM_RD_BYPASS_EN
//                defined     - write-first forwarding on a same-address
//                              read/write collision (rd_data gets wr_data)
//                not defined - read-before-write (rd_data gets the old word)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_alt #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Storage powers up cleared through the declaration initialiser; it has
    // no reset path, so a reset never disturbs frame-buffer contents.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // An X on an enable yields X here, which the if() below treats as false,
    // so an unknown enable behaves as "not enabled".
    assign w_wr_fire = (wr_en == 1'b0);
    assign w_rd_fire = (rd_en == 1'b0);

`ifdef DATA_MEM_RD_BYPASS_EN
    // Write-first: forward the incoming word on a same-address collision.
    assign w_rd_word = (w_wr_fire && (rd_addr == wr_addr)) ? wr_data
                                                            : r_mem[rd_addr];
`else
    // Read-before-write: the array read sees the word stored before this edge.
    assign w_rd_word = r_mem[rd_addr];
`endif

    // Write port: independent of reset, writes land even while reset is high.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port: reset clears the output register immediately and blocks reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rd_fire) begin
            r_rd_data <= w_rd_word;
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_alt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_alt
//  Description : Self-checking bench for data_mem_alt (DATA_WIDTH=16,
//                ADDR_WIDTH=3). Directed scenarios plus a randomized run
//                checked against a behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_alt;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: plain array of words plus the expected output word.
    logic [DW-1:0] model_mem [8];
    logic [DW-1:0] exp_rd;

`ifdef DATA_MEM_RD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    data_mem_alt #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one rising edge, updating the model from the inputs present at
    // that edge, then return 1 time unit after the edge.
    task automatic step();
        logic [DW-1:0] nxt;
        nxt = exp_rd;
        if (reset) begin
            nxt = '0;
        end else if (rd_en == 1'b0) begin
            if (BYPASS && wr_en == 1'b0 && rd_addr == wr_addr)
                nxt = wr_data;
            else
                nxt = model_mem[rd_addr];
        end
        if (wr_en == 1'b0) model_mem[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        exp_rd = nxt;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        step(); step();
        reset = 1'b0;
        step();
        n_total++;
        if (rd_data !== 16'h0000) $display("FAIL reset_state: rd_data=%h expected=%h", rd_data, 16'h0000);
        else n_pass++;
        // load a non-zero word and read it back
        wr_en = 1'b0; wr_addr = 3'd6; wr_data = 16'h5A5A;
        step();
        wr_en = 1'b1; rd_en = 1'b0; rd_addr = 3'd6;
        step();
        n_total++;
        if (rd_data !== 16'h5A5A) $display("FAIL reset_preload: rd_data=%h expected=%h", rd_data, 16'h5A5A);
        else n_pass++;
        // mid-cycle asynchronous reset
        rd_en = 1'b1;
        #5 reset = 1'b1;
        #1;
        exp_rd = '0;
        n_total++;
        if (rd_data !== 16'h0000) $display("FAIL reset_async: rd_data=%h expected=%h", rd_data, 16'h0000);
        else n_pass++;
        #2 reset = 1'b0;
        step();
        n_total++;
        if (rd_data !== 16'h0000) $display("FAIL reset_release_hold: rd_data=%h expected=%h", rd_data, 16'h0000);
        else n_pass++;
    endtask

    task automatic test_write_read();
        wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_addr = AW'(i); wr_data = DW'(i);
            step();
        end
        wr_en = 1'b1; rd_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rd_addr = AW'(i);
            step();
            n_total++;
            if (rd_data !== DW'(i)) $display("FAIL write_read[%0d]: rd_data=%h expected=%h", i, rd_data, DW'(i));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        wr_en = 1'b1; rd_en = 1'b0; rd_addr = 3'd3;
        step();
        rd_en = 1'b1; rd_addr = 3'd4;
        step(); step();
        n_total++;
        if (rd_data !== 16'h0003) $display("FAIL hold: rd_data=%h expected=%h", rd_data, 16'h0003);
        else n_pass++;
    endtask

    task automatic test_disabled_write();
        wr_en = 1'b1; wr_data = 16'hBEEF; wr_addr = 3'd5; rd_en = 1'b1;
        step();
        rd_en = 1'b0; rd_addr = 3'd5;
        step();
        n_total++;
        if (rd_data !== 16'h0000) $display("FAIL disabled_write: rd_data=%h expected=%h", rd_data, 16'h0000);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [DW-1:0] first_exp;
        first_exp = BYPASS ? 16'h00AA : 16'h0002;
        wr_en = 1'b0; rd_en = 1'b0; wr_addr = 3'd2; rd_addr = 3'd2; wr_data = 16'h00AA;
        step();
        n_total++;
        if (rd_data !== first_exp) $display("FAIL collision: rd_data=%h expected=%h", rd_data, first_exp);
        else n_pass++;
        wr_en = 1'b1;
        step();
        n_total++;
        if (rd_data !== 16'h00AA) $display("FAIL collision_next: rd_data=%h expected=%h", rd_data, 16'h00AA);
        else n_pass++;
    endtask

    task automatic test_reset_writes();
        reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd7; wr_data = 16'h1234;
        rd_en = 1'b0; rd_addr = 3'd7;
        step();
        n_total++;
        if (rd_data !== 16'h0000) $display("FAIL reset_write_rd0: rd_data=%h expected=%h", rd_data, 16'h0000);
        else n_pass++;
        wr_en = 1'b1;
        step();
        n_total++;
        if (rd_data !== 16'h0000) $display("FAIL reset_write_rd1: rd_data=%h expected=%h", rd_data, 16'h0000);
        else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if (rd_data !== 16'h1234) $display("FAIL reset_write_read: rd_data=%h expected=%h", rd_data, 16'h1234);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            wr_en   = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            rd_en   = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            wr_addr = AW'($urandom_range(0, 7));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
            wr_data = DW'($urandom);
            step();
            n_total++;
            if (rd_data !== exp_rd) begin
                if (errs < 10) $display("FAIL random[%0d]: rd_data=%h expected=%h", n, rd_data, exp_rd);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        exp_rd = '0;
        test_reset();
        test_write_read();
        test_hold();
        test_disabled_write();
        test_collision();
        test_reset_writes();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_alt.md
Name: data_mem_alt

Overview:
- Simple dual-port synchronous RAM: one write port and one read port, both on a single clock.
- Used as the frame-buffer data store: pixel words are written at one address while another address is read back.
- Read data is registered: one cycle of latency, output held between reads.
- Write and read enables are active-low, matching the FPGA block-RAM wrapper style used in the frame buffer.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of wr_data/rd_data.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  single clock; all sampling on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  active-low write enable.
- rd_en  input  1  active-low read enable.
- wr_addr  input  ADDR_WIDTH  write address.
- rd_addr  input  ADDR_WIDTH  read address.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Array: 2**ADDR_WIDTH x DATA_WIDTH. All words power up as 0 (initialised storage).
- The array has no reset path. Reset never alters stored contents.
- Reset assertion immediately forces rd_data to 0, with no clock needed.
- While reset is high, rd_data stays 0 and reads are ignored.
- Writes are still accepted while reset is high; the write path is independent of reset.
- Write: at a rising clk with wr_en==0, mem[wr_addr] <= wr_data. With wr_en==1, the array is unchanged.
- Read: at a rising clk with rd_en==0 and reset low, rd_data <= mem[rd_addr]. Data is visible after that edge (1-cycle latency).
- With rd_en==1, rd_data holds its previous value.
- Same-address read and write in one edge (default build): read-before-write. rd_data gets the old word; the new word is readable from the next edge.
- Different addresses in the same edge are fully independent.
- Addresses wrap naturally: every ADDR_WIDTH-bit value is valid, so there is no out-of-range case.
- Any X on an enable: treat as not enabled. This is simulation-only guidance, not a synthesis requirement.
- Reset released mid-operation: the first read takes effect at the first rising edge after reset falls with rd_en==0.

Optional Feature:
- Macro: DATA_MEM_RD_BYPASS_EN.
- Defined: write-first forwarding. If rd_en==0, wr_en==0 and rd_addr==wr_addr at the same edge, rd_data <= wr_data. The array is still written.
- Not defined: read-before-write as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=3, clock period 20):
- Reset: assert reset mid-cycle while rd_data holds non-zero data -> rd_data becomes 0 immediately, before any clock edge. Release reset -> rd_data stays 0 until the next enabled read.
- Write then read: write 0x0001..0x0004 to addrs 1..4 (wr_en=0, rd_en=1). Then set wr_en=1, rd_en=0 and step rd_addr 1..4 -> rd_data = 0x0001, 0x0002, 0x0003, 0x0004, each one edge after its address is sampled.
- Hold: after reading 0x0003 from addr 3, set rd_en=1 and change rd_addr to 4 -> rd_data stays 0x0003.
- Disabled write: wr_en=1, wr_data=0xBEEF, wr_addr=5, then read addr 5 -> 0x0000 (power-up value).
- Collision: addr 2 holds 0x0002; write 0x00AA to addr 2 while reading addr 2 in the same edge.
  - Without the macro: rd_data=0x0002, and the next read gives 0x00AA.
  - With DATA_MEM_RD_BYPASS_EN: rd_data=0x00AA.
- Reset with writes: hold reset high, write 0x1234 to addr 7, release reset, read addr 7 -> 0x1234. rd_data is 0 throughout reset.
